// File: rtl/hazard_ctrl_pipe.sv
// Hazard controller for an in-order pipeline of STAGES registers.
// Drives PC stall plus per-register stall/flush. Handles:
// - data-memory stalls
// - load-use bubbles (LU_BUBBLES per hazard)
// - branch/jump redirects, including one that arrives during an
//   instruction-fetch miss
// - a sequenced mode-switch drain that ends in a one-cycle acknowledge
// Optional macro HAZARD_PERF_EN adds three free-running 32-bit
// performance counters.
module hazard_ctrl_pipe #(
  parameter int STAGES     = 4,
  parameter int RA_W       = 5,
  parameter int LU_BUBBLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_stall,
  input  logic              mem_stall,
  input  logic              redirect,
  input  logic              switch_req,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              ex_is_load,
  input  logic [RA_W-1:0]   ex_rd,
  input  logic              ex_rd_we,
  output logic              pc_stall,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] flush,
  output logic              switch_ack,
  output logic              busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_stall_cyc,
  output logic [31:0]       perf_lu_cnt,
  output logic [31:0]       perf_redir_cnt
`endif
);

  localparam int MAXC = (STAGES > LU_BUBBLES) ? STAGES : LU_BUBBLES;
  localparam int CW   = $clog2(MAXC + 1);

  // Memory stall: freeze every register except the last, which takes a bubble.
  localparam logic [STAGES-1:0] MEM_STALL = {1'b0, {(STAGES-1){1'b1}}};
  localparam logic [STAGES-1:0] MEM_FLUSH = {1'b1, {(STAGES-1){1'b0}}};
  localparam logic [STAGES-1:0] BIT0      = STAGES'(1);
  localparam logic [STAGES-1:0] BIT1      = STAGES'(2);

  typedef enum logic [2:0] {
    S_RUN,
    S_LU_HOLD,
    S_REDIR_WAIT,
    S_DRAIN,
    S_SWITCH
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  logic              pc_stall_c;
  logic [STAGES-1:0] stall_c;
  logic [STAGES-1:0] flush_c;
  logic              ack_c;
  logic              lu_hit;
  logic              lu_take;
  logic              redir_take;

  assign lu_hit = ex_is_load & ex_rd_we & (ex_rd != '0) &
                  ((id_rs1_used & (id_rs1 == ex_rd)) |
                   (id_rs2_used & (id_rs2 == ex_rd)));

  // Output decode and next-state selection, by state and then by input priority.
  always_comb begin
    pc_stall_c = 1'b0;
    stall_c    = '0;
    flush_c    = '0;
    ack_c      = 1'b0;
    lu_take    = 1'b0;
    redir_take = 1'b0;
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_RUN: begin
        if (mem_stall) begin
          pc_stall_c = 1'b1;
          stall_c    = MEM_STALL;
          flush_c    = MEM_FLUSH;
        end else if (switch_req) begin
          pc_stall_c = 1'b1;
          flush_c    = BIT0;
          state_next = S_DRAIN;
          cnt_next   = CW'(STAGES - 1);
        end else if (redirect) begin
          flush_c    = BIT0 | BIT1;
          redir_take = 1'b1;
          if (if_stall) state_next = S_REDIR_WAIT;
        end else if (lu_hit) begin
          pc_stall_c = 1'b1;
          stall_c    = BIT0;
          flush_c    = BIT1;
          lu_take    = 1'b1;
          if (LU_BUBBLES > 1) begin
            state_next = S_LU_HOLD;
            cnt_next   = CW'(LU_BUBBLES - 1);
          end
        end else if (if_stall) begin
          pc_stall_c = 1'b1;
          flush_c    = BIT0;
        end
      end
      S_LU_HOLD: begin
        if (mem_stall) begin
          // Bubble count stays frozen while memory holds the pipe.
          pc_stall_c = 1'b1;
          stall_c    = MEM_STALL;
          flush_c    = MEM_FLUSH;
        end else if (redirect) begin
          // The stalled ID instruction is on the wrong path; drop the hold.
          flush_c    = BIT0 | BIT1;
          redir_take = 1'b1;
          state_next = S_RUN;
          cnt_next   = '0;
        end else begin
          pc_stall_c = 1'b1;
          stall_c    = BIT0;
          flush_c    = BIT1;
          if (cnt_reg <= CW'(1)) begin
            state_next = S_RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - CW'(1);
          end
        end
      end
      S_REDIR_WAIT: begin
        if (mem_stall) begin
          pc_stall_c = 1'b1;
          stall_c    = MEM_STALL;
          flush_c    = MEM_FLUSH;
        end else begin
          // The fetch in flight is from the old path; discard it on arrival.
          flush_c = BIT0;
          if (!if_stall) state_next = S_RUN;
        end
      end
      S_DRAIN: begin
        pc_stall_c = 1'b1;
        if (mem_stall) begin
          // IF/ID keeps taking bubbles, so it is flushed rather than held.
          stall_c = MEM_STALL & ~BIT0;
          flush_c = MEM_FLUSH | BIT0;
        end else begin
          flush_c    = BIT0 | (redirect ? BIT1 : '0);
          redir_take = redirect;
          if (cnt_reg <= CW'(1)) begin
            state_next = S_SWITCH;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - CW'(1);
          end
        end
      end
      S_SWITCH: begin
        ack_c      = 1'b1;
        flush_c    = '1;
        state_next = S_RUN;
      end
      default: begin
        state_next = S_RUN;
        cnt_next   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // While reset is held, force every output quiet regardless of inputs.
  assign pc_stall   = rst_n & pc_stall_c;
  assign stall      = rst_n ? stall_c : '0;
  assign flush      = rst_n ? flush_c : '0;
  assign switch_ack = rst_n & ack_c;
  assign busy       = rst_n & (state_reg != S_RUN);

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_reg, perf_lu_reg, perf_redir_reg;

  // Event counters; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_reg <= '0;
      perf_lu_reg    <= '0;
      perf_redir_reg <= '0;
    end else begin
      perf_stall_reg <= perf_stall_reg + 32'(pc_stall_c);
      perf_lu_reg    <= perf_lu_reg + 32'(lu_take);
      perf_redir_reg <= perf_redir_reg + 32'(redir_take);
    end
  end

  assign perf_stall_cyc = perf_stall_reg;
  assign perf_lu_cnt    = perf_lu_reg;
  assign perf_redir_cnt = perf_redir_reg;
`else
  // Event strobes only feed the optional counters.
  logic perf_unused;
  assign perf_unused = lu_take | redir_take;
`endif

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Scoreboard bench for hazard_ctrl_pipe (STAGES=4, LU_BUBBLES=2).
// The driver steps a behavioural model and queues expected outputs.
// A negedge monitor pops the queue and compares against the DUT.
module tb_hazard_ctrl_pipe;

  localparam int S  = 4;
  localparam int RW = 5;
  localparam int LB = 2;

  typedef struct packed {
    logic         pc;
    logic [S-1:0] st;
    logic [S-1:0] fl;
    logic         ack;
    logic         busy;
  } exp_t;

  logic          clk, rst_n;
  logic          if_stall, mem_stall, redirect, switch_req;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_rs1_used, id_rs2_used, ex_is_load, ex_rd_we;
  logic          pc_stall, switch_ack, busy;
  logic [S-1:0]  stall, flush;

  hazard_ctrl_pipe #(.STAGES(S), .RA_W(RW), .LU_BUBBLES(LB)) dut (
    .clk(clk), .rst_n(rst_n), .if_stall(if_stall), .mem_stall(mem_stall),
    .redirect(redirect), .switch_req(switch_req), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .pc_stall(pc_stall), .stall(stall),
    .flush(flush), .switch_ack(switch_ack), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  // Model: what is still owed to the pipeline, as plain counts/flags.
  int m_lu_left    = 0;  // load-use bubbles still to insert after this one
  int m_drain_left = 0;  // drain cycles still to run
  bit m_rw         = 0;  // waiting for the wrong-path fetch to land
  bit m_sw         = 0;  // acknowledge due this cycle
  bit last_ack     = 0;

  // Monitor-side observation counters for the directed scenarios.
  int obs_pc, obs_st0, obs_f0, obs_f1, obs_ack, obs_cyc, ack_cyc;

  function automatic exp_t mem_rule(input exp_t e_in);
    exp_t e = e_in;
    e.pc = 1'b1;
    for (int k = 0; k < S - 1; k++) e.st[k] = 1'b1;
    e.fl[S-1] = 1'b1;
    return e;
  endfunction

  task automatic model_step(output exp_t e);
    bit hit;
    e = '0;
    hit = ex_is_load && ex_rd_we && (ex_rd != 0) &&
          ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    if (m_sw) begin
      e.ack = 1'b1; e.fl = '1; e.busy = 1'b1; m_sw = 0;
    end else if (m_drain_left > 0) begin
      e.busy = 1'b1; e.pc = 1'b1; e.fl[0] = 1'b1;
      if (mem_stall) begin
        for (int k = 1; k < S - 1; k++) e.st[k] = 1'b1;
        e.fl[S-1] = 1'b1;
      end else begin
        if (redirect) e.fl[1] = 1'b1;
        m_drain_left = m_drain_left - 1;
        if (m_drain_left == 0) m_sw = 1;
      end
    end else if (m_rw) begin
      e.busy = 1'b1;
      if (mem_stall) e = mem_rule(e);
      else begin
        e.fl[0] = 1'b1;
        if (!if_stall) m_rw = 0;
      end
    end else if (m_lu_left > 0) begin
      e.busy = 1'b1;
      if (mem_stall) e = mem_rule(e);
      else if (redirect) begin
        e.fl[0] = 1'b1; e.fl[1] = 1'b1; m_lu_left = 0;
      end else begin
        e.pc = 1'b1; e.st[0] = 1'b1; e.fl[1] = 1'b1;
        m_lu_left = m_lu_left - 1;
      end
    end else begin
      if (mem_stall) e = mem_rule(e);
      else if (switch_req) begin
        e.pc = 1'b1; e.fl[0] = 1'b1; m_drain_left = S - 1;
      end else if (redirect) begin
        e.fl[0] = 1'b1; e.fl[1] = 1'b1;
        if (if_stall) m_rw = 1;
      end else if (hit) begin
        e.pc = 1'b1; e.st[0] = 1'b1; e.fl[1] = 1'b1; m_lu_left = LB - 1;
      end else if (if_stall) begin
        e.pc = 1'b1; e.fl[0] = 1'b1;
      end
    end
  endtask

  task automatic set_idle();
    if_stall = 0; mem_stall = 0; redirect = 0; switch_req = 0;
    id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_is_load = 0; ex_rd = 0; ex_rd_we = 0;
  endtask

  // One pipeline cycle: apply inputs after the edge, queue the expectation.
  task automatic drive(input bit ifs, input bit mem, input bit red, input bit sw,
                       input bit ld, input bit we, input logic [RW-1:0] rd,
                       input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                       input bit u1, input bit u2);
    exp_t e;
    @(posedge clk);
    #1;
    if_stall = ifs; mem_stall = mem; redirect = red; switch_req = sw;
    ex_is_load = ld; ex_rd_we = we; ex_rd = rd;
    id_rs1 = r1; id_rs2 = r2; id_rs1_used = u1; id_rs2_used = u2;
    model_step(e);
    last_ack = e.ack;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_obs();
    obs_pc = 0; obs_st0 = 0; obs_f0 = 0; obs_f1 = 0; obs_ack = 0; obs_cyc = 0; ack_cyc = -1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Monitor: compare every clocked cycle outside reset against the scoreboard.
  exp_t mon_exp, mon_got;
  always @(negedge clk) begin
    if (rst_n) begin
      mon_got.pc = pc_stall; mon_got.st = stall; mon_got.fl = flush;
      mon_got.ack = switch_ack; mon_got.busy = busy;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty t=%0t got %h", $time, mon_got);
      end else begin
        mon_exp = sb_q.pop_front();
        if (mon_got !== mon_exp) begin
          bad++;
          $display("FAIL scoreboard t=%0t got pc=%b st=%b fl=%b ack=%b busy=%b, expected pc=%b st=%b fl=%b ack=%b busy=%b",
                   $time, mon_got.pc, mon_got.st, mon_got.fl, mon_got.ack, mon_got.busy,
                   mon_exp.pc, mon_exp.st, mon_exp.fl, mon_exp.ack, mon_exp.busy);
        end
      end
      obs_pc  += int'(pc_stall);
      obs_st0 += int'(stall[0]);
      obs_f0  += int'(flush[0]);
      obs_f1  += int'(flush[1]);
      if (switch_ack) begin
        obs_ack++;
        ack_cyc = obs_cyc;
      end
      obs_cyc++;
    end
  end

  initial begin
    bit req_hold;
    set_idle();
    clr_obs();
    rst_n = 1'b0;
    mem_stall = 1'b1;
    #1;
    chk("reset_pc_stall", int'(pc_stall), 0);
    chk("reset_stall", int'(stall), 0);
    chk("reset_flush", int'(flush), 0);
    chk("reset_busy", int'(busy), 0);
    set_idle();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Load x5 in EX, ID reads x5 via rs2: two bubbles.
    clr_obs();
    drive(0, 0, 0, 0, 1, 1, 5, 0, 5, 0, 1);
    drive(0, 0, 0, 0, 1, 1, 5, 0, 5, 0, 1);
    idle(3);
    sync();
    chk("lu_bubbles_pc", obs_pc, 2);
    chk("lu_bubbles_stall0", obs_st0, 2);
    $display("scenario load_use: pc_stall cycles=%0d", obs_pc);

    // Load to x0 must never stall.
    clr_obs();
    drive(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1);
    idle(1);
    sync();
    chk("lu_x0_pc", obs_pc, 0);
    $display("scenario load_x0: pc_stall cycles=%0d", obs_pc);

    // Redirect during a 3-cycle fetch miss.
    clr_obs();
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    sync();
    chk("redir_flush0", obs_f0, 4);
    chk("redir_flush1", obs_f1, 1);
    chk("redir_pc", obs_pc, 0);
    $display("scenario redirect_wait: flush0 cycles=%0d", obs_f0);

    // Mode switch, no stalls: ack on the 5th cycle (index 4).
    clr_obs();
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    sync();
    chk("switch_ack_cnt", obs_ack, 1);
    chk("switch_ack_cyc", ack_cyc, 4);
    $display("scenario switch: ack at cycle %0d", ack_cyc);

    // Mode switch with two mem_stall cycles mid-drain.
    clr_obs();
    for (int i = 0; i < 7; i++) drive(0, (i == 2 || i == 3), 0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    sync();
    chk("switch_mem_ack_cnt", obs_ack, 1);
    chk("switch_mem_ack_cyc", ack_cyc, 6);
    $display("scenario switch_mem: ack at cycle %0d", ack_cyc);

    // Reset asserted while holding a load-use bubble.
    drive(0, 0, 0, 0, 1, 1, 7, 7, 0, 1, 0);
    @(posedge clk);
    #1 sb_q.delete();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_pc", int'(pc_stall), 0);
    chk("rst_mid_stall", int'(stall), 0);
    chk("rst_mid_flush", int'(flush), 0);
    chk("rst_mid_busy", int'(busy), 0);
    m_lu_left = 0; m_drain_left = 0; m_rw = 0; m_sw = 0;
    repeat (2) @(negedge clk);
    #1 set_idle();
    rst_n = 1'b1;
    clr_obs();
    drive(0, 0, 0, 0, 1, 1, 7, 7, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 1, 7, 7, 0, 1, 0);
    idle(2);
    sync();
    chk("rst_fresh_lu_pc", obs_pc, 2);
    $display("scenario reset_mid_lu: fresh bubble cycles=%0d", obs_pc);

    // Randomized traffic; switch_req is held until ack, dropped right after.
    req_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!req_hold && $urandom_range(0, 39) == 0) req_hold = 1;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, req_hold,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
            RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
            RW'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1);
      if (last_ack) req_hold = 0;
    end
    idle(1);
    sync();
    $display("scenario random: 3000 cycles issued");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
